acs_result_checker: RTL and testbench

//  Response end of the adder_cum_sub stimulus path: samples {a,b,sel,out,cout_or_borrow} from the DUT boundary,

---
 rtl/acs_result_checker_if.sv | 20 ++
 rtl/acs_result_checker.sv | 161 ++++++++++++++++
 tb/tb_acs_result_checker.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acs_result_checker_if.sv
// acs_result_checker_if: monitor bundle sampled at the adder_cum_sub boundary.
// The master drives the sampled values and the checker consumes them as slave.
interface acs_result_checker_if #(
    parameter int WIDTH = 4
) ();
    logic             mon_valid;
    logic [WIDTH-1:0] mon_a;
    logic [WIDTH-1:0] mon_b;
    logic             mon_sel;
    logic [WIDTH-1:0] mon_out;
    logic             mon_cob;

    modport master (
        output mon_valid, mon_a, mon_b, mon_sel, mon_out, mon_cob
    );

    modport slave (
        input mon_valid, mon_a, mon_b, mon_sel, mon_out, mon_cob
    );
endinterface

// File: rtl/acs_result_checker.sv
// acs_result_checker: golden-model response checker for adder_cum_sub.
// Define ACS_CHK_FAILCAP_EN to capture the first failing vector of a run.
module acs_result_checker #(
    parameter int WIDTH       = 4,
    parameter int CNT_W       = 16,
    parameter int NUM_VECTORS = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    acs_result_checker_if.slave  mon,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mismatch,
    output logic [CNT_W-1:0]     vec_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     fail_idx,
    output logic [2*WIDTH+1:0]   fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [31:0]      NV_LAST = 32'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q, state_d;

    logic             accept;
    logic             last_smp;
    logic             clear;
    logic [31:0]      acc_q, acc_d;

    logic             s1_vld_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_out_q;
    logic             s1_sel_q, s1_cob_q;

    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   exp_w;
    logic             s1_fail;

    logic [CNT_W-1:0] vec_q, err_q;
    logic             mm_q;

    // Next state: sample acceptance, run limit, drain until S1 is empty
    always_comb begin
        accept   = (state_q == ST_RUN) && mon.mon_valid;
        last_smp = (NUM_VECTORS != 0) && accept && (acc_q == NV_LAST);
        clear    = 1'b0;
        state_d  = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop || last_smp) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_vld_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        acc_d = clear ? '0 : (accept ? acc_q + 32'd1 : acc_q);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Golden result of the S1 sample and its verdict
    always_comb begin
        diff = s1_a_q - s1_b_q;
        if (s1_sel_q) exp_w = {(s1_a_q < s1_b_q), diff};
        else          exp_w = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        s1_fail = s1_vld_q && ({s1_cob_q, s1_out_q} != exp_w);
    end

    // S1 capture and S2 counters/mismatch pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_sel_q <= 1'b0;
            s1_out_q <= '0;
            s1_cob_q <= 1'b0;
            mm_q     <= 1'b0;
            vec_q    <= '0;
            err_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            s1_vld_q <= accept;
            if (accept) begin
                s1_a_q   <= mon.mon_a;
                s1_b_q   <= mon.mon_b;
                s1_sel_q <= mon.mon_sel;
                s1_out_q <= mon.mon_out;
                s1_cob_q <= mon.mon_cob;
            end
            mm_q <= s1_fail;
            if (clear) begin
                vec_q <= '0;
                err_q <= '0;
            end else if (s1_vld_q) begin
                if (vec_q != CNT_MAX) vec_q <= vec_q + 1'b1;
                if (s1_fail && (err_q != CNT_MAX)) err_q <= err_q + 1'b1;
            end
        end
    end

`ifdef ACS_CHK_FAILCAP_EN
    logic [CNT_W-1:0]   fidx_q;
    logic [2*WIDTH+1:0] fvec_q;

    // Hold the first failing vector of the run until the next start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fidx_q <= '0;
            fvec_q <= '0;
        end else if (clear) begin
            fidx_q <= '0;
            fvec_q <= '0;
        end else if (s1_fail && (err_q == '0)) begin
            fidx_q <= vec_q;
            fvec_q <= {s1_a_q, s1_b_q, s1_sel_q, s1_cob_q};
        end
    end

    assign fail_idx = fidx_q;
    assign fail_vec = fvec_q;
`else
    assign fail_idx = '0;
    assign fail_vec = '0;
`endif

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign pass     = done && (err_q == '0);
    assign mismatch = mm_q;
    assign vec_cnt  = vec_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_acs_result_checker.sv
// tb_acs_result_checker: directed tables, corner sequences and random run
// against a plain-arithmetic reference of the adder/subtractor checker.
module tb_acs_result_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] stop_v;

    always #5 clk = ~clk;

    acs_result_checker_if #(.WIDTH(4)) mif ();

    // d0: unlimited, 16-bit counters
    logic        b0, dn0, p0, m0;
    logic [15:0] vc0, ec0, fi0;
    logic [9:0]  fv0;
    // d1: NUM_VECTORS = 3
    logic        b1, dn1, p1, m1;
    logic [15:0] vc1, ec1, fi1;
    logic [9:0]  fv1;
    // d2: CNT_W = 2, unlimited
    logic        b2, dn2, p2, m2;
    logic [1:0]  vc2, ec2, fi2;
    logic [9:0]  fv2;

    acs_result_checker #(.WIDTH(4), .CNT_W(16), .NUM_VECTORS(0)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]),
        .mon(mif), .busy(b0), .done(dn0), .pass(p0), .mismatch(m0),
        .vec_cnt(vc0), .err_cnt(ec0), .fail_idx(fi0), .fail_vec(fv0)
    );

    acs_result_checker #(.WIDTH(4), .CNT_W(16), .NUM_VECTORS(3)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]),
        .mon(mif), .busy(b1), .done(dn1), .pass(p1), .mismatch(m1),
        .vec_cnt(vc1), .err_cnt(ec1), .fail_idx(fi1), .fail_vec(fv1)
    );

    acs_result_checker #(.WIDTH(4), .CNT_W(2), .NUM_VECTORS(0)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stop(stop_v[2]),
        .mon(mif), .busy(b2), .done(dn2), .pass(p2), .mismatch(m2),
        .vec_cnt(vc2), .err_cnt(ec2), .fail_idx(fi2), .fail_vec(fv2)
    );

    typedef struct {
        int a;
        int b;
        int sel;
        int out;
        int cob;
        int bad;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input int sel,
                        input int out, input int cob);
        mif.mon_valid = 1'b1;
        mif.mon_a     = 4'(a);
        mif.mon_b     = 4'(b);
        mif.mon_sel   = 1'(sel);
        mif.mon_out   = 4'(out);
        mif.mon_cob   = 1'(cob);
    endtask

    task automatic idle();
        mif.mon_valid = 1'b0;
    endtask

    task automatic pulse_start(input int id);
        start_v[id] = 1'b1;
        step();
        start_v[id] = 1'b0;
    endtask

    function automatic logic done_of(input int id);
        case (id)
            0:       return dn0;
            1:       return dn1;
            default: return dn2;
        endcase
    endfunction

    task automatic wait_done(input int id, input string nm);
        int c = 0;
        while (!done_of(id) && c < 10) begin
            step();
            c++;
        end
        chk(nm, int'(done_of(id)), 1);
    endtask

    // Reference: does (out, cob) differ from the true add/subtract result?
    function automatic int is_bad(input int a, input int b, input int sel,
                                  input int out, input int cob);
        int r, eo, ec;
        if (sel != 0) begin
            r  = a - b;
            ec = (a < b) ? 1 : 0;
        end else begin
            r  = a + b;
            ec = (r > 15) ? 1 : 0;
        end
        eo = r & 15;
        return ((eo != out) || (ec != cob)) ? 1 : 0;
    endfunction

    function automatic int fvec(input int a, input int b, input int sel,
                                input int cob);
        return (a << 6) | (b << 2) | (sel << 1) | cob;
    endfunction

    function automatic int cap(input int v);
`ifdef ACS_CHK_FAILCAP_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    vec_t tbl[12];
    int   q[$];

    initial begin
        int nbad, first, acc, errs, fidx, fv, c;
        int a, b, sel, out, cob, bad;

        tbl[0]  = '{7, 9, 0, 0, 1, 0};
        tbl[1]  = '{3, 5, 1, 14, 1, 0};
        tbl[2]  = '{9, 2, 1, 7, 0, 0};
        tbl[3]  = '{15, 1, 0, 0, 0, 1};
        tbl[4]  = '{15, 15, 0, 14, 1, 0};
        tbl[5]  = '{0, 15, 1, 1, 1, 0};
        tbl[6]  = '{0, 0, 1, 0, 0, 0};
        tbl[7]  = '{8, 8, 1, 0, 1, 1};
        tbl[8]  = '{4, 4, 0, 8, 0, 0};
        tbl[9]  = '{12, 3, 0, 15, 0, 0};
        tbl[10] = '{5, 6, 1, 15, 0, 1};
        tbl[11] = '{1, 2, 0, 4, 0, 1};

        rst_n   = 1'b0;
        start_v = '0;
        stop_v  = '0;
        idle();
        mif.mon_a   = '0;
        mif.mon_b   = '0;
        mif.mon_sel = 1'b0;
        mif.mon_out = '0;
        mif.mon_cob = 1'b0;
        step();
        step();

        chk("rst_busy", int'(b0), 0);
        chk("rst_done", int'(dn0), 0);
        chk("rst_pass", int'(p0), 0);
        chk("rst_mismatch", int'(m0), 0);
        chk("rst_vec", int'(vc0), 0);
        chk("rst_err", int'(ec0), 0);
        chk("rst_fidx", int'(fi0), 0);
        chk("rst_fvec", int'(fv0), 0);
        rst_n = 1'b1;
        step();

        // Three correct vectors complete a NUM_VECTORS=3 run
        pulse_start(1);
        chk("n3_busy", int'(b1), 1);
        send(7, 9, 0, 0, 1);
        step();
        send(3, 5, 1, 14, 1);
        step();
        send(9, 2, 1, 7, 0);
        step();
        idle();
        wait_done(1, "n3_done");
        chk("n3_vec", int'(vc1), 3);
        chk("n3_err", int'(ec1), 0);
        chk("n3_pass", int'(p1), 1);
        chk("idle_ignore_vec", int'(vc0), 0);

        // Samples while DONE are ignored
        send(1, 1, 0, 0, 0);
        step();
        step();
        idle();
        step();
        step();
        chk("done_ignore_vec", int'(vc1), 3);
        chk("done_ignore_err", int'(ec1), 0);

        // Failing first vector, stop on the 3rd, extra sample ignored
        pulse_start(1);
        chk("restart_vec", int'(vc1), 0);
        send(15, 1, 0, 0, 0);
        step();
        chk("mm_early", int'(m1), 0);
        send(7, 9, 0, 0, 1);
        step();
        chk("mm_pulse", int'(m1), 1);
        send(9, 2, 1, 7, 0);
        stop_v[1] = 1'b1;
        step();
        stop_v[1] = 1'b0;
        chk("mm_clear", int'(m1), 0);
        send(15, 1, 0, 0, 0);
        step();
        idle();
        wait_done(1, "n3f_done");
        chk("n3f_vec", int'(vc1), 3);
        chk("n3f_err", int'(ec1), 1);
        chk("n3f_pass", int'(p1), 0);
        chk("n3f_fidx", int'(fi1), 0);
        chk("n3f_fvec", int'(fv1), cap(fvec(15, 1, 0, 0)));

        // Unlimited run, 10 back-to-back, stop with the 10th
        pulse_start(0);
        for (int i = 0; i < 10; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            send(a, b, 0, (a + b) & 15, (a + b) > 15 ? 1 : 0);
            if (i == 9) stop_v[0] = 1'b1;
            step();
        end
        stop_v[0] = 1'b0;
        idle();
        c = 0;
        while (!dn0 && c < 5) begin
            step();
            c++;
        end
        chk("drain_lat_ok", (c <= 3) ? 1 : 0, 1);
        chk("b2b_vec", int'(vc0), 10);
        chk("b2b_err", int'(ec0), 0);
        chk("b2b_pass", int'(p0), 1);

        // Table of single isolated vectors
        pulse_start(0);
        nbad  = 0;
        first = -1;
        foreach (tbl[i]) begin
            send(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].out, tbl[i].cob);
            step();
            idle();
            step();
            chk($sformatf("tbl%0d_mm", i), int'(m0), tbl[i].bad);
            if (tbl[i].bad != 0) begin
                if (first < 0) first = i;
                nbad++;
            end
        end
        stop_v[0] = 1'b1;
        step();
        stop_v[0] = 1'b0;
        wait_done(0, "tbl_done");
        chk("tbl_vec", int'(vc0), 12);
        chk("tbl_err", int'(ec0), nbad);
        chk("tbl_pass", int'(p0), 0);
        chk("tbl_fidx", int'(fi0), cap(first));
        chk("tbl_fvec", int'(fv0), cap(fvec(15, 1, 0, 0)));

        // Random run against the reference
        pulse_start(0);
        acc  = 0;
        errs = 0;
        fidx = 0;
        fv   = 0;
        q.delete();
        for (int i = 0; i < 300; i++) begin
            bad = 0;
            if ($urandom_range(0, 9) < 6) begin
                a   = int'($urandom_range(0, 15));
                b   = int'($urandom_range(0, 15));
                sel = int'($urandom_range(0, 1));
                if (sel != 0) begin
                    out = (a - b) & 15;
                    cob = (a < b) ? 1 : 0;
                end else begin
                    out = (a + b) & 15;
                    cob = (a + b) > 15 ? 1 : 0;
                end
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0) out = (out + 1) & 15;
                    else                           cob = 1 - cob;
                end
                bad = is_bad(a, b, sel, out, cob);
                if (bad != 0) begin
                    if (errs == 0) begin
                        fidx = acc;
                        fv   = fvec(a, b, sel, cob);
                    end
                    errs++;
                end
                acc++;
                send(a, b, sel, out, cob);
            end else begin
                idle();
            end
            start_v[0] = (i == 150) ? 1'b1 : 1'b0;
            stop_v[0]  = (i == 299) ? 1'b1 : 1'b0;
            q.push_back(bad);
            step();
            if (q.size() == 2) chk("rnd_mm", int'(m0), q.pop_front());
        end
        start_v[0] = 1'b0;
        stop_v[0]  = 1'b0;
        idle();
        step();
        chk("rnd_mm_last", int'(m0), q.pop_front());
        wait_done(0, "rnd_done");
        chk("rnd_vec", int'(vc0), acc);
        chk("rnd_err", int'(ec0), errs);
        chk("rnd_pass", int'(p0), (errs == 0) ? 1 : 0);
        chk("rnd_fidx", int'(fi0), cap(fidx));
        chk("rnd_fvec", int'(fv0), cap(fv));

        // Reset one cycle after a failing sample
        pulse_start(0);
        send(15, 1, 0, 0, 0);
        step();
        idle();
        rst_n = 1'b0;
        step();
        chk("rstmid_mm", int'(m0), 0);
        chk("rstmid_busy", int'(b0), 0);
        chk("rstmid_done", int'(dn0), 0);
        chk("rstmid_vec", int'(vc0), 0);
        chk("rstmid_err", int'(ec0), 0);
        rst_n = 1'b1;
        step();
        step();
        chk("rstmid_mm_after", int'(m0), 0);
        chk("rstmid_err_after", int'(ec0), 0);

        // Saturating 2-bit counters
        pulse_start(2);
        for (int i = 0; i < 5; i++) begin
            send(i, 1, 0, 0, 0);
            if (i == 4) stop_v[2] = 1'b1;
            step();
        end
        stop_v[2] = 1'b0;
        idle();
        wait_done(2, "sat_done");
        chk("sat_err", int'(ec2), 3);
        chk("sat_vec", int'(vc2), 3);
        chk("sat_pass", int'(p2), 0);
        pulse_start(2);
        chk("sat_restart_vec", int'(vc2), 0);
        chk("sat_restart_err", int'(ec2), 0);
        chk("sat_restart_busy", int'(b2), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
